keypad_scan_interface: RTL and testbench

Matrix keypad scanner for the board's 4x4 keypad, the input-side counterpart to the multiplexed seven-segment display driver. It drives one row low at a time, samples the active-low columns, and debounces each full scan frame. It publishes a clean key code with a single-cycle press strobe for the controller and the display logic, using one clock and no handshake back-pressure.

---
 rtl/keypad_scan_interface.sv | 241 ++++++++++++++++++++++++
 tb/tb_keypad_scan_interface.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_interface.sv
// 4x4 matrix keypad scanner: row drive, 2-flop column sync, per-frame debounce, one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_scan_interface #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  // key_valid is a strobe without back-pressure: a consumer must take key_code in the cycle key_valid is high.

  localparam int DW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [1:0] CLS_NONE  = 2'd0;
  localparam logic [1:0] CLS_ONE   = 2'd1;
  localparam logic [1:0] CLS_MULTI = 2'd2;

  if (SETTLE_CYCLES < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scan_interface: invalid parameter set");
  end

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    acc_cls_q, acc_cls_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic          sample, frame_end, accept, rep_pulse;
  logic [3:0]    col_low;
  logic [2:0]    row_ones;
  logic [1:0]    col_idx;
  logic [1:0]    merged_cls;
  logic [3:0]    merged_code;

  assign sample    = (dwell_q == DWELL_LAST);
  assign frame_end = sample && (row_q == 2'd3);
  assign col_low   = ~col_s2_q;

  always_comb begin
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    row_d   = sample ? row_q + 2'd1 : row_q;
  end

  always_comb begin
    row_ones = 3'd0;
    col_idx  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (col_low[c]) begin
        row_ones = row_ones + 3'd1;
        col_idx  = 2'(c);
      end
    end
  end

  // Running classification of the frame so far, including the row being sampled now.
  always_comb begin
    merged_cls  = CLS_NONE;
    merged_code = acc_code_q;
    if (acc_cls_q == CLS_MULTI || row_ones > 3'd1 || (acc_cls_q == CLS_ONE && row_ones == 3'd1)) begin
      merged_cls = CLS_MULTI;
    end else if (acc_cls_q == CLS_ONE) begin
      merged_cls = CLS_ONE;
    end else if (row_ones == 3'd1) begin
      merged_cls  = CLS_ONE;
      merged_code = {row_q, col_idx};
    end
  end

  always_comb begin
    acc_cls_d  = acc_cls_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      acc_cls_d  = frame_end ? CLS_NONE : merged_cls;
      acc_code_d = frame_end ? 4'h0 : merged_code;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    key_code_d = key_code_q;
    key_held_d = key_held_q;
    accept     = 1'b0;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (merged_cls == CLS_ONE) begin
            cand_d  = merged_code;
            cnt_d   = CNT_ONE;
            state_d = ST_DEBOUNCE;
            accept  = (CNT_ONE == CNT_MAX);
          end
        end
        ST_DEBOUNCE: begin
          if (merged_cls == CLS_ONE && merged_code == cand_q) begin
            cnt_d  = cnt_inc;
            accept = (cnt_inc == CNT_MAX);
          end else if (merged_cls == CLS_ONE) begin
            cand_d = merged_code;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (merged_cls == CLS_NONE) begin
            state_d = ST_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          if (merged_cls == CLS_NONE && cnt_inc != CNT_MAX) begin
            cnt_d = cnt_inc;
          end else if (merged_cls == CLS_ONE && merged_code == key_code_q) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            key_held_d = 1'b0;
          end
        end
      endcase
      if (accept) begin
        state_d    = ST_PRESSED;
        cnt_d      = '0;
        key_code_d = cand_d;
        key_held_d = 1'b1;
      end
    end
  end

  assign key_valid_d = accept | rep_pulse;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW    = $clog2(RPMAX + 1);
  localparam logic [RW-1:0] REP_DELAY_L = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RATE_L  = RW'(REPEAT_RATE);

  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          rep_armed_q, rep_armed_d;

  // rep_q restarts after every strobe, so it is bounded by the larger interval and never wraps.
  always_comb begin
    rep_d       = rep_q;
    rep_armed_d = rep_armed_q;
    rep_pulse   = 1'b0;
    rep_inc     = rep_q + RW'(1);
    if (accept) begin
      rep_d       = '0;
      rep_armed_d = 1'b0;
    end else if (frame_end && state_q == ST_PRESSED && merged_cls == CLS_ONE && merged_code == key_code_q) begin
      if (rep_inc >= (rep_armed_q ? REP_RATE_L : REP_DELAY_L)) begin
        rep_pulse   = 1'b1;
        rep_d       = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      dwell_q     <= '0;
      row_q       <= 2'd0;
      acc_cls_q   <= CLS_NONE;
      acc_code_q  <= 4'h0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_s1_q    <= col_n;
      col_s2_q    <= col_s1_q;
      dwell_q     <= dwell_d;
      row_q       <= row_d;
      acc_cls_q   <= acc_cls_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan_interface.sv
// Directed bench for keypad_scan_interface: SETTLE=4, DEBOUNCE=3, REPEAT 5/2, so one frame is 16 cycles.
module tb_keypad_scan_interface;

  localparam int FRAME = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K3  = 16'h0008;
  localparam logic [15:0] K56 = 16'h0060;

  logic        clock;
  logic        reset;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [1:0]  dbg_state;
  logic [15:0] keys_down;

  int checks = 0;
  int passes = 0;
  int valid_cnt = 0;

  keypad_scan_interface #(
    .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clock(clock), .reset(reset), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad model: key {r,c} pulls column c low while row r is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(negedge clock) if (key_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_frame(input logic [15:0] keys);
    keys_down = keys;
    repeat (FRAME) @(posedge clock);
    #1;
  endtask

  task automatic align_frame();
    int n = 0;
    keys_down = 16'h0;
    while (row_n !== 4'b0111 && n < 40) begin @(posedge clock); #1; n++; end
    while (row_n !== 4'b1110 && n < 40) begin @(posedge clock); #1; n++; end
    checks++; if (n >= 40) $display("FAIL align_timeout: waited %0d cycles, limit 40", n); else passes++;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    keys_down = 16'h0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (row_n !== 4'b1110) $display("FAIL reset_row_n: got %b expected 1110", row_n); else passes++;
    checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else passes++;
    checks++; if (key_code !== 4'h0) $display("FAIL reset_key_code: got %h expected 0", key_code); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b expected 0", key_held); else passes++;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clock); #1;
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      checks++; if (row_n !== exp_row) $display("FAIL scan_row_n[%0d]: got %b expected %b", k, row_n, exp_row); else passes++;
    end
    for (int f = 0; f < 2; f++) begin
      run_frame(16'h0);
      checks++; if (key_valid !== 1'b0) $display("FAIL idle_key_valid: got %b expected 0", key_valid); else passes++;
      checks++; if (key_held !== 1'b0) $display("FAIL idle_key_held: got %b expected 0", key_held); else passes++;
    end
    checks++; if (valid_cnt !== 0) $display("FAIL idle_strobes: got %0d expected 0", valid_cnt); else passes++;
  endtask

  task automatic test_press_release();
    int base = valid_cnt;
    align_frame();
    for (int f = 1; f <= 2; f++) begin
      run_frame(K9);
      checks++; if (key_valid !== 1'b0) $display("FAIL press_early_valid[%0d]: got %b expected 0", f, key_valid); else passes++;
      checks++; if (key_held !== 1'b0) $display("FAIL press_early_held[%0d]: got %b expected 0", f, key_held); else passes++;
    end
    run_frame(K9);
    checks++; if (key_valid !== 1'b1) $display("FAIL press_accept_valid: got %b expected 1", key_valid); else passes++;
    checks++; if (key_code !== 4'h9) $display("FAIL press_accept_code: got %h expected 9", key_code); else passes++;
    checks++; if (key_held !== 1'b1) $display("FAIL press_accept_held: got %b expected 1", key_held); else passes++;
    @(posedge clock); #1;
    checks++; if (key_valid !== 1'b0) $display("FAIL press_strobe_width: got %b expected 0", key_valid); else passes++;
    repeat (FRAME - 1) @(posedge clock);
    #1;
    run_frame(K9);
    checks++; if (key_held !== 1'b1) $display("FAIL press_hold_held: got %b expected 1", key_held); else passes++;
    for (int f = 1; f <= 3; f++) begin
      run_frame(16'h0);
      checks++; if (key_held !== (f < 3)) $display("FAIL release_held[%0d]: got %b expected %b", f, key_held, f < 3); else passes++;
    end
    checks++; if (key_code !== 4'h9) $display("FAIL release_code_kept: got %h expected 9", key_code); else passes++;
    checks++; if (valid_cnt - base !== 1) $display("FAIL press_strobes: got %0d expected 1", valid_cnt - base); else passes++;
  endtask

  task automatic test_bounce();
    int base = valid_cnt;
    align_frame();
    for (int i = 0; i < 6; i++) begin
      run_frame(K9);
      checks++; if (key_held !== 1'b0) $display("FAIL bounce_held_on[%0d]: got %b expected 0", i, key_held); else passes++;
      run_frame(16'h0);
      checks++; if (key_held !== 1'b0) $display("FAIL bounce_held_off[%0d]: got %b expected 0", i, key_held); else passes++;
    end
    checks++; if (valid_cnt - base !== 0) $display("FAIL bounce_strobes: got %0d expected 0", valid_cnt - base); else passes++;
  endtask

  task automatic test_multi();
    int base = valid_cnt;
    align_frame();
    for (int f = 1; f <= 3; f++) run_frame(K56);
    checks++; if (key_held !== 1'b0) $display("FAIL multi_idle_held: got %b expected 0", key_held); else passes++;
    checks++; if (valid_cnt - base !== 0) $display("FAIL multi_idle_strobes: got %0d expected 0", valid_cnt - base); else passes++;
    for (int f = 1; f <= 3; f++) run_frame(K9);
    checks++; if (key_valid !== 1'b1) $display("FAIL multi_accept_valid: got %b expected 1", key_valid); else passes++;
    for (int f = 1; f <= 3; f++) begin
      run_frame(K9 | K3);
      checks++; if (key_valid !== 1'b0) $display("FAIL multi_extra_valid[%0d]: got %b expected 0", f, key_valid); else passes++;
      checks++; if (key_code !== 4'h9) $display("FAIL multi_extra_code[%0d]: got %h expected 9", f, key_code); else passes++;
      checks++; if (key_held !== 1'b1) $display("FAIL multi_extra_held[%0d]: got %b expected 1", f, key_held); else passes++;
    end
    for (int f = 1; f <= 3; f++) run_frame(16'h0);
    checks++; if (key_held !== 1'b0) $display("FAIL multi_release_held: got %b expected 0", key_held); else passes++;
    checks++; if (valid_cnt - base !== 1) $display("FAIL multi_strobes: got %0d expected 1", valid_cnt - base); else passes++;
  endtask

  task automatic test_reset_mid_debounce();
    int base = valid_cnt;
    align_frame();
    run_frame(K9);
    run_frame(K9);
    repeat (6) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (row_n !== 4'b1110) $display("FAIL midreset_row_n: got %b expected 1110", row_n); else passes++;
    checks++; if (key_code !== 4'h0) $display("FAIL midreset_code: got %h expected 0", key_code); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL midreset_held: got %b expected 0", key_held); else passes++;
    checks++; if (key_valid !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", key_valid); else passes++;
    @(negedge clock);
    reset = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      run_frame(K9);
      checks++; if (key_valid !== (f == 3)) $display("FAIL midreset_fresh_valid[%0d]: got %b expected %b", f, key_valid, f == 3); else passes++;
    end
    checks++; if (key_code !== 4'h9) $display("FAIL midreset_fresh_code: got %h expected 9", key_code); else passes++;
    for (int f = 1; f <= 3; f++) run_frame(16'h0);
    checks++; if (valid_cnt - base !== 1) $display("FAIL midreset_strobes: got %0d expected 1", valid_cnt - base); else passes++;
  endtask

  task automatic test_repeat();
    int base = valid_cnt;
    logic exp_v;
    align_frame();
    for (int f = 1; f <= 14; f++) begin
      run_frame(K9);
      exp_v = (f == 3) || (REP_EN && f >= 8 && (f % 2) == 0);
      checks++; if (key_valid !== exp_v) $display("FAIL repeat_valid[%0d]: got %b expected %b", f, key_valid, exp_v); else passes++;
    end
    for (int f = 1; f <= 3; f++) run_frame(16'h0);
    checks++; if (valid_cnt - base !== (REP_EN ? 5 : 1)) $display("FAIL repeat_strobes: got %0d expected %0d", valid_cnt - base, REP_EN ? 5 : 1); else passes++;
  endtask

  initial begin
    reset = 1'b1;
    keys_down = 16'h0;
    test_reset();
    test_press_release();
    test_bounce();
    test_multi();
    test_reset_mid_debounce();
    test_repeat();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
